router_ctrl: RTL and testbench
==============================

# router_ctrl

Write-side controller for the 1x3 router. It decodes the header address of each incoming packet and steers it into one of the three output FIFOs. It sequences header/payload/parity loading through an 8-state Moore FSM, stalls the source while the target FIFO is full or still draining, and raises per-FIFO valid and soft-reset (read-timeout) strobes. It sits between the input register block and the three FIFO instances.

## Interface
- `TIMEOUT`, 30: cycles a FIFO may hold valid data with no read before its soft reset fires (5..63).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `pkt_valid` in 1: source is presenting packet bytes.
- `data_in` in 8: input byte; bits [1:0] are the header address (0..2 valid, 3 invalid).
- `full_0`, `full_1`, `full_2` in 1 each: FIFO full flags.
- `empty_0`, `empty_1`, `empty_2` in 1 each: FIFO empty flags.
- `read_enb_0`, `read_enb_1`, `read_enb_2` in 1 each: destination read strobes.
- `parity_done` in 1: register block has captured parity.
- `low_pkt_valid` in 1: `pkt_valid` fell while the FSM was in full stall.
- `write_enb` out 3: one-hot FIFO write enable.
- `fifo_full` out 1: full flag of the latched-address FIFO.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg`, `busy` out 1 each: state decodes.
- `vld_out_0`, `vld_out_1`, `vld_out_2` out 1 each: FIFO has data.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` out 1 each: registered one-cycle timeout pulses to the FIFOs.

## Operation
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
- Address register `addr`:
  - Loads `data_in[1:0]` when `detect_add & pkt_valid`.
  - Indexes `full_n`, `empty_n` and `soft_reset_n`.
- Transitions:
  - DECODE_ADDRESS:
    - `pkt_valid` & addr≠3 & `empty[addr]` → LOAD_FIRST_DATA.
    - `pkt_valid` & addr≠3 & !`empty[addr]` → WAIT_TILL_EMPTY.
    - Otherwise stay. Addr 3 is dropped.
  - LOAD_FIRST_DATA → LOAD_DATA, unconditionally.
  - LOAD_DATA:
    - `fifo_full` → FIFO_FULL_STATE.
    - Else !`pkt_valid` → LOAD_PARITY.
    - Else stay.
  - LOAD_PARITY → CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: `fifo_full` → FIFO_FULL_STATE; else → DECODE_ADDRESS.
  - FIFO_FULL_STATE: !`fifo_full` → LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - `parity_done` → DECODE_ADDRESS.
    - Else `low_pkt_valid` → LOAD_PARITY.
    - Else → LOAD_DATA.
  - WAIT_TILL_EMPTY: `empty[addr]` → LOAD_FIRST_DATA; else stay.
  - Any state: `soft_reset[addr]` high → DECODE_ADDRESS. This has priority over all other transitions.
- Moore outputs, one-hot per state:
  - `detect_add`=DECODE_ADDRESS.
  - `lfd_state`=LOAD_FIRST_DATA.
  - `ld_state`=LOAD_DATA.
  - `laf_state`=LOAD_AFTER_FULL.
  - `full_state`=FIFO_FULL_STATE.
  - `rst_int_reg`=CHECK_PARITY_ERROR.
- `busy`=1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Write enable:
  - Internal `write_enb_reg`=1 in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL.
  - `write_enb` = `write_enb_reg` ? (3'b001<<addr) : 3'b000. Never more than one bit high.
- `vld_out_n` = !`empty_n`, combinational.
- Timeout counter, per FIFO, width ceil(log2 TIMEOUT):
  - Increments while `vld_out_n` & !`read_enb_n`.
  - Clears on `read_enb_n` or !`vld_out_n`.
  - At count TIMEOUT-1: `soft_reset_n` asserts for the next cycle only, and the counter clears.

## Timing
- Reset values:
  - State DECODE_ADDRESS, so `detect_add`=1 and all other decodes are 0.
  - `busy`=0, `write_enb`=0, `addr`=0, counters 0, all `soft_reset_n`=0.
  - `vld_out_n` follows `empty_n`.
- Decodes are valid the cycle after a state change. No combinational input→decode path except `fifo_full` and `vld_out_n`.
- Header accepted at edge N (DECODE_ADDRESS with `pkt_valid`, target empty):
  - Cycle N+1: `lfd_state`=1.
  - Cycle N+2 onward: `ld_state`=1 and `write_enb`=1 while payload streams.
- Reset asserted mid-packet: returns to DECODE_ADDRESS immediately and clears counters. Any partially written FIFO is the FIFO's concern.
- Soft reset with no read: `soft_reset_n` first high exactly TIMEOUT cycles after `vld_out_n` rises. A read in the same cycle as the terminal count suppresses the pulse.

## Structure
- Shared `router_pkg` holds:
  - State enum.
  - `ADDR_W`=2.
  - `NUM_PORTS`=3.
  - Default `TIMEOUT`=30.
- Sub-module `router_sft_timer` holds one timeout counter and its pulse register, instantiated three times. The FSM, address latch and write-enable decode stay in `router_ctrl`.

## Test plan
- Header 8'h39 (len 14, addr 1) to empty FIFO 1, then 14 payload bytes, then `pkt_valid` low → `write_enb`=3'b010 for 15 cycles, LOAD_PARITY → CHECK_PARITY_ERROR → DECODE_ADDRESS. `busy` is low during payload.
- Header to addr 2 with `empty_2`=0 → WAIT_TILL_EMPTY and `busy`=1; release `empty_2` → LOAD_FIRST_DATA the next cycle.
- `full_1` raised mid-payload → FIFO_FULL_STATE and `write_enb`=0; drop `full_1` with `low_pkt_valid`=1 → LOAD_AFTER_FULL → LOAD_PARITY.
- Header addr 3 → FSM stays in DECODE_ADDRESS and `write_enb` stays 0.
- `empty_0`=0 with no `read_enb_0` for 30 cycles → one-cycle `soft_reset_0` on cycle 30; a `read_enb_0` at cycle 29 → no pulse.
- Assert `rst` low during LOAD_DATA → `detect_add`=1 and `write_enb`=0 asynchronously.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router write-side controller.
package router_pkg;

    localparam int ADDR_W      = 2;
    localparam int NUM_PORTS   = 3;
    localparam int TIMEOUT_DEF = 30;

    // Header address 3 has no FIFO behind it; such packets are dropped.
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        LOAD_PARITY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        WAIT_TILL_EMPTY,
        CHECK_PARITY_ERROR
    } state_t;

endpackage

// File: rtl/router_sft_timer.sv
// Read-timeout watchdog for one FIFO: counts idle cycles with valid data and
// emits a registered one-cycle soft reset at the terminal count.
module router_sft_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic vld_out,
    input  logic read_enb,
    output logic soft_reset
);

    localparam int               CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;
    logic             hit;

    // A read landing on the terminal count wins: no pulse, counter restarts.
    assign hit = vld_out && !read_enb && (count == TERM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= hit;
            if (!vld_out || read_enb || hit) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_ctrl.sv
// Write-side controller of the 1x3 router: header decode, load-sequencing FSM,
// per-FIFO valid flags and read-timeout soft resets.
module router_ctrl
    import router_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 full_0,
    input  logic                 full_1,
    input  logic                 full_2,
    input  logic                 empty_0,
    input  logic                 empty_1,
    input  logic                 empty_2,
    input  logic                 read_enb_0,
    input  logic                 read_enb_1,
    input  logic                 read_enb_2,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 fifo_full,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic                 vld_out_0,
    output logic                 vld_out_1,
    output logic                 vld_out_2,
    output logic                 soft_reset_0,
    output logic                 soft_reset_1,
    output logic                 soft_reset_2
);

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr, sel_addr;
    logic [3:0]        full_v, empty_v, sft_v;
    logic              write_enb_reg;
    logic              unused_hdr;

    // Address 3 indexes a constant-0 slot so the flag vectors need no guards.
    assign full_v  = {1'b0, full_2, full_1, full_0};
    assign empty_v = {1'b0, empty_2, empty_1, empty_0};
    assign sft_v   = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

    // The header byte is live on data_in while decoding; afterwards the latch holds it.
    assign sel_addr   = (state == DECODE_ADDRESS) ? data_in[ADDR_W-1:0] : addr;
    assign fifo_full  = full_v[addr];
    assign write_enb  = write_enb_reg ? (NUM_PORTS'(1) << addr) : '0;
    assign unused_hdr = ^data_in[DATA_W-1:ADDR_W];

    assign vld_out_0 = !empty_0;
    assign vld_out_1 = !empty_1;
    assign vld_out_2 = !empty_2;

    router_sft_timer #(.TIMEOUT(TIMEOUT)) u_tmr_0 (
        .clk(clk), .rst(rst), .vld_out(vld_out_0), .read_enb(read_enb_0), .soft_reset(soft_reset_0)
    );
    router_sft_timer #(.TIMEOUT(TIMEOUT)) u_tmr_1 (
        .clk(clk), .rst(rst), .vld_out(vld_out_1), .read_enb(read_enb_1), .soft_reset(soft_reset_1)
    );
    router_sft_timer #(.TIMEOUT(TIMEOUT)) u_tmr_2 (
        .clk(clk), .rst(rst), .vld_out(vld_out_2), .read_enb(read_enb_2), .soft_reset(soft_reset_2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DECODE_ADDRESS;
            addr  <= '0;
        end else begin
            state <= next_state;
            if (detect_add && pkt_valid) begin
                addr <= data_in[ADDR_W-1:0];
            end
        end
    end

    always_comb begin
        next_state    = state;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        write_enb_reg = 1'b0;
        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                if (pkt_valid && (sel_addr != ADDR_INVALID)) begin
                    next_state = empty_v[sel_addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: begin
                lfd_state  = 1'b1;
                busy       = 1'b1;
                next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                if (fifo_full)       next_state = FIFO_FULL_STATE;
                else if (!pkt_valid) next_state = LOAD_PARITY;
            end
            LOAD_PARITY: begin
                busy          = 1'b1;
                write_enb_reg = 1'b1;
                next_state    = CHECK_PARITY_ERROR;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
                if (!fifo_full) next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                busy          = 1'b1;
                write_enb_reg = 1'b1;
                if (parity_done)        next_state = DECODE_ADDRESS;
                else if (low_pkt_valid) next_state = LOAD_PARITY;
                else                    next_state = LOAD_DATA;
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
                if (empty_v[addr]) next_state = LOAD_FIRST_DATA;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
                next_state  = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
        endcase
        // A timed-out FIFO abandons whatever the FSM was doing.
        if (sft_v[addr]) next_state = DECODE_ADDRESS;
    end

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: packet flow, stall paths, dropped header,
// read-timeout pulses and asynchronous reset.
module tb_router_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       full_0 = 1'b0, full_1 = 1'b0, full_2 = 1'b0;
    logic       empty_0 = 1'b1, empty_1 = 1'b1, empty_2 = 1'b1;
    logic       read_enb_0 = 1'b0, read_enb_1 = 1'b0, read_enb_2 = 1'b0;
    logic       parity_done = 1'b0, low_pkt_valid = 1'b0;
    logic [2:0] write_enb;
    logic       fifo_full, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, busy, vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int n_checks = 0;
    int n_fail   = 0;

    // Decode vector order: detect_add, lfd, ld, laf, full, rst_int_reg, busy.
    localparam logic [6:0] S_DEC = 7'b1000000;
    localparam logic [6:0] S_LFD = 7'b0100001;
    localparam logic [6:0] S_LD  = 7'b0010000;
    localparam logic [6:0] S_LAF = 7'b0001001;
    localparam logic [6:0] S_FUL = 7'b0000101;
    localparam logic [6:0] S_CPE = 7'b0000011;
    localparam logic [6:0] S_BSY = 7'b0000001;

    router_ctrl dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
        .full_0(full_0), .full_1(full_1), .full_2(full_2),
        .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
        .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .write_enb(write_enb), .fifo_full(fifo_full), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .busy(busy),
        .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec();
        return {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_dec", dec(), S_DEC);
        chk("rst_we", write_enb, 3'b000);
        chk("rst_sft", {soft_reset_2, soft_reset_1, soft_reset_0}, 3'b000);
        chk("rst_vld", {vld_out_2, vld_out_1, vld_out_0}, 3'b000);
        empty_1 = 1'b0;
        #1;
        chk("rst_vld_follow", {vld_out_2, vld_out_1, vld_out_0}, 3'b010);
        empty_1 = 1'b1;
        tick();
        chk("rst_hold_dec", dec(), S_DEC);
        rst = 1'b1;
        tick();

        // Packet 8'h39 to empty FIFO 1: 14 payload cycles plus parity
        data_in = 8'h39; pkt_valid = 1'b1;
        tick();
        chk("p1_lfd", dec(), S_LFD);
        chk("p1_lfd_we", write_enb, 3'b000);
        data_in = 8'hA0;
        tick();
        for (int i = 0; i < 14; i++) begin
            chk("p1_ld", dec(), S_LD);
            chk("p1_ld_we", write_enb, 3'b010);
            data_in = 8'(i);
            if (i == 13) pkt_valid = 1'b0;
            tick();
        end
        chk("p1_lp", dec(), S_BSY);
        chk("p1_lp_we", write_enb, 3'b010);
        tick();
        chk("p1_cpe", dec(), S_CPE);
        chk("p1_cpe_we", write_enb, 3'b000);
        tick();
        chk("p1_dec", dec(), S_DEC);

        // Header to non-empty FIFO 2 waits until it drains
        data_in = 8'h06; empty_2 = 1'b0; pkt_valid = 1'b1;
        tick();
        chk("p2_wte", dec(), S_BSY);
        chk("p2_wte_we", write_enb, 3'b000);
        tick();
        chk("p2_wte_hold", dec(), S_BSY);
        empty_2 = 1'b1;
        tick();
        chk("p2_lfd", dec(), S_LFD);
        tick();
        chk("p2_ld_we", write_enb, 3'b100);
        pkt_valid = 1'b0;
        tick();
        chk("p2_lp_we", write_enb, 3'b100);
        tick();
        chk("p2_cpe", dec(), S_CPE);
        tick();
        chk("p2_dec", dec(), S_DEC);

        // Full stall mid-payload on FIFO 1, resumed with low_pkt_valid
        data_in = 8'h05; pkt_valid = 1'b1;
        tick();
        chk("p3_lfd", dec(), S_LFD);
        tick();
        chk("p3_ld_we", write_enb, 3'b010);
        full_1 = 1'b1;
        #1;
        chk("p3_fifo_full", fifo_full, 1'b1);
        tick();
        chk("p3_full", dec(), S_FUL);
        chk("p3_full_we", write_enb, 3'b000);
        tick();
        chk("p3_full_hold", dec(), S_FUL);
        full_1 = 1'b0; pkt_valid = 1'b0; low_pkt_valid = 1'b1;
        #1;
        chk("p3_fifo_clr", fifo_full, 1'b0);
        tick();
        chk("p3_laf", dec(), S_LAF);
        chk("p3_laf_we", write_enb, 3'b010);
        tick();
        chk("p3_lp", dec(), S_BSY);
        chk("p3_lp_we", write_enb, 3'b010);
        low_pkt_valid = 1'b0;
        tick();
        chk("p3_cpe", dec(), S_CPE);
        tick();
        chk("p3_dec", dec(), S_DEC);

        // Address 3 is dropped
        data_in = 8'h07; pkt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("a3_dec", dec(), S_DEC);
            chk("a3_we", write_enb, 3'b000);
        end
        pkt_valid = 1'b0;
        tick();

        // Timeout on FIFO 0 with no reads: pulse on cycle 30 only
        empty_0 = 1'b0;
        #1;
        chk("t0_vld", vld_out_0, 1'b1);
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk("t0_sft", soft_reset_0, (k == 30) ? 1'b1 : 1'b0);
        end
        empty_0 = 1'b1;
        tick();
        tick();

        // A read on the terminal-count cycle suppresses the pulse
        empty_0 = 1'b0;
        for (int k = 1; k <= 29; k++) tick();
        read_enb_0 = 1'b1;
        tick();
        read_enb_0 = 1'b0;
        chk("t1_sft_supp", soft_reset_0, 1'b0);
        tick();
        chk("t1_sft_after", soft_reset_0, 1'b0);
        empty_0 = 1'b1;
        tick();
        tick();

        // Soft reset of the latched FIFO pulls the FSM out of WAIT_TILL_EMPTY
        data_in = 8'h00; pkt_valid = 1'b1; empty_0 = 1'b0;
        tick();
        pkt_valid = 1'b0;
        chk("t2_wte", dec(), S_BSY);
        for (int k = 2; k <= 30; k++) tick();
        chk("t2_sft", soft_reset_0, 1'b1);
        chk("t2_wte_still", dec(), S_BSY);
        tick();
        chk("t2_dec", dec(), S_DEC);
        empty_0 = 1'b1;
        tick();

        // Asynchronous reset during LOAD_DATA
        data_in = 8'h01; pkt_valid = 1'b1;
        tick();
        tick();
        chk("r_ld", dec(), S_LD);
        chk("r_ld_we", write_enb, 3'b010);
        #2;
        rst = 1'b0;
        #1;
        chk("r_async_dec", dec(), S_DEC);
        chk("r_async_we", write_enb, 3'b000);
        tick();
        rst = 1'b1; pkt_valid = 1'b0;
        tick();
        chk("r_after_dec", dec(), S_DEC);
        chk("r_after_we", write_enb, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
